ifetch_responder: RTL

- Responder end of the core's instruction-fetch handshake. The sequencer pulses fetch_en with a PC; this block reads instruction memory and returns one 32-bit instruction with a single-cycle instr_en strobe.
- Sits between the fetch/decode controller and the 64-bit-wide instruction SRAM port.
- Handles word selection within a 64-bit memory beat, configurable memory latency, misaligned-PC faults and overrun detection.

---
 rtl/ifetch_responder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ifetch_responder.sv
// Instruction-fetch responder: reads one 64-bit SRAM beat per aligned fetch and returns the selected 32-bit word.
// Define IFETCH_LINE_BUF_EN to add a one-entry line buffer and the ibuf_flush input.
module ifetch_responder #(
    parameter int AW      = 64,
    parameter int IW      = 32,
    parameter int MW      = 64,
    parameter int LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_en,
    input  logic [AW-1:0] pc,
    output logic [IW-1:0] instr_out,
    output logic          instr_en,
    output logic          instr_fault,
    output logic          overrun,
    output logic          busy,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
`ifdef IFETCH_LINE_BUF_EN
    input  logic          ibuf_flush,
`endif
    input  logic [MW-1:0] mem_rdata
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $fatal(1, "ifetch_responder: LATENCY must be in 1..15");
    end
    if (MW != 2 * IW) begin : g_bad_width
        $fatal(1, "ifetch_responder: MW must equal 2*IW");
    end

    localparam logic [3:0] LAT_CNT = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MEM,
        RESP
    } state_e;

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic          lane_q;
    logic [IW-1:0] instr_out_q;
    logic          instr_en_q;
    logic          instr_fault_q;
    logic          overrun_q;
    logic          busy_q;
    logic          mem_rd_en_q;
    logic [AW-1:0] mem_addr_q;

    logic [IW-1:0] rd_word_d;
    logic          rd_done_d;
    logic          buf_hit_d;
    logic [IW-1:0] buf_word_d;

    // The memory beat carries two instructions; pc[2] picks the upper one.
    assign rd_word_d = lane_q ? mem_rdata[MW-1:IW] : mem_rdata[IW-1:0];
    assign rd_done_d = (state_q == WAIT_MEM) && (cnt_q == 4'd0);

`ifdef IFETCH_LINE_BUF_EN
    logic                buf_valid_q;
    logic [AW-4:0]       buf_tag_q;
    logic [MW-1:0]       buf_data_q;

    // A flush in the same cycle as a lookup must not be bypassed by stale data.
    assign buf_hit_d  = buf_valid_q && !ibuf_flush && (buf_tag_q == pc[AW-1:3]);
    assign buf_word_d = pc[2] ? buf_data_q[MW-1:IW] : buf_data_q[IW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
        end else if (ibuf_flush) begin
            buf_valid_q <= 1'b0;
        end else if (rd_done_d) begin
            buf_valid_q <= 1'b1;
        end
    end

    // NOTE: tag and data storage carry no reset; the valid bit alone guards them.
    always_ff @(posedge clk) begin
        if (rd_done_d) begin
            buf_tag_q  <= mem_addr_q[AW-1:3];
            buf_data_q <= mem_rdata;
        end
    end
`else
    assign buf_hit_d  = 1'b0;
    assign buf_word_d = '0;
`endif

    // NOTE: every state register uses <= so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            lane_q        <= 1'b0;
            instr_out_q   <= '0;
            instr_en_q    <= 1'b0;
            instr_fault_q <= 1'b0;
            overrun_q     <= 1'b0;
            busy_q        <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            mem_addr_q    <= '0;
        end else begin
            instr_en_q  <= 1'b0;
            mem_rd_en_q <= 1'b0;
            overrun_q   <= fetch_en && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (fetch_en) begin
                        busy_q <= 1'b1;
                        if (pc[1:0] != 2'b00) begin
                            instr_out_q   <= '0;
                            instr_fault_q <= 1'b1;
                            instr_en_q    <= 1'b1;
                            state_q       <= RESP;
                        end else if (buf_hit_d) begin
                            instr_out_q   <= buf_word_d;
                            instr_fault_q <= 1'b0;
                            instr_en_q    <= 1'b1;
                            state_q       <= RESP;
                        end else begin
                            lane_q      <= pc[2];
                            mem_addr_q  <= {pc[AW-1:3], 3'b000};
                            mem_rd_en_q <= 1'b1;
                            cnt_q       <= LAT_CNT;
                            state_q     <= WAIT_MEM;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (cnt_q == 4'd0) begin
                        instr_out_q   <= rd_word_d;
                        instr_fault_q <= 1'b0;
                        instr_en_q    <= 1'b1;
                        state_q       <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign instr_out   = instr_out_q;
    assign instr_en    = instr_en_q;
    assign instr_fault = instr_fault_q;
    assign overrun     = overrun_q;
    assign busy        = busy_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_addr    = mem_addr_q;

endmodule
